// File: rtl/xalu_obuf_mt_pkg.sv
// Shared types and defaults for the xalu result buffer.
// Holds library record types used between FUs, the buffer and the IU.
package xalu_obuf_mt_pkg;

    localparam int OBUF_NTHREAD = 64;
    localparam int OBUF_NFU     = 2;
    localparam int OBUF_DW      = 32;
    localparam int OBUF_TW      = $clog2(OBUF_NTHREAD);
    localparam int OBUF_YW      = 32;
    localparam int OBUF_NZVW    = 3;

    typedef struct packed {
        logic [OBUF_TW-1:0]   tid;
        logic [OBUF_DW-1:0]   res;
        logic [OBUF_NZVW-1:0] nzv;
        logic [OBUF_YW-1:0]   y;
    } xalu_obuf_wr_type;

    typedef struct packed {
        logic                 valid;
        logic [OBUF_DW-1:0]   res;
        logic [OBUF_NZVW-1:0] nzv;
        logic [OBUF_YW-1:0]   y;
        logic                 perr;
    } xalu_obuf_rd_type;

    localparam xalu_obuf_rd_type xalu_obuf_rd_none = '0;

endpackage

// File: rtl/xalu_obuf_mt_rr_arb.sv
// N-way round-robin arbiter, one-hot grant.
// Search starts at the pointer; pointer moves past the winner.
module xalu_rr_arb
    import xalu_obuf_mt_pkg::*;
#(
    parameter int N = OBUF_NFU,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;
    int            s;

    // pick the first requester at or after the pointer
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        s     = 0;
        for (int o = 0; o < N; o++) begin
            s = int'(ptr) + o;
            if (s >= N) s = s - N;
            idx = PW'(s);
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gidx      = idx;
            end
        end
    end

    // advance pointer past the granted requester
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (found) begin
            if (int'(gidx) == N - 1) ptr <= '0;
            else                     ptr <= gidx + PW'(1);
        end
    end

endmodule

// File: rtl/xalu_obuf_mt.sv
// Per-thread result buffer between xalu FUs and IU writeback.
// Optional parity protection: define XALU_OBUF_PARITY_EN.
module xalu_obuf_mt
    import xalu_obuf_mt_pkg::*;
#(
    parameter int NTHREAD = OBUF_NTHREAD,
    parameter int NFU     = OBUF_NFU,
    parameter int DW      = OBUF_DW,
    localparam int TW     = $clog2(NTHREAD)
) (
    input  logic              gclk,
    input  logic              rstn,
    input  logic [NFU-1:0]    fu_valid,
    input  logic [NFU*TW-1:0] fu_tid,
    input  logic [NFU*DW-1:0] fu_res,
    input  logic [NFU*3-1:0]  fu_nzv,
    input  logic [NFU*32-1:0] fu_y,
    output logic [NFU-1:0]    fu_ready,
    input  logic              rd_en,
    input  logic [TW-1:0]     rd_tid,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_res,
    output logic [2:0]        rd_nzv,
    output logic [31:0]       rd_y,
    output logic              rd_perr,
    input  logic              replay_en,
    input  logic [TW-1:0]     replay_tid,
    output logic [TW:0]       occ_cnt
);

    typedef struct packed {
        logic [TW-1:0] tid;
        logic [DW-1:0] res;
        logic [2:0]    nzv;
        logic [31:0]   y;
    } wr_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] res;
        logic [2:0]    nzv;
        logic [31:0]   y;
        logic          perr;
    } rd_t;

    logic [NTHREAD-1:0] valid;
    logic [NTHREAD-1:0] valid_nxt;
    logic [DW-1:0]      res_mem [NTHREAD];
    logic [2:0]         nzv_mem [NTHREAD];
    logic [31:0]        y_mem   [NTHREAD];

    wr_t           fu_a [NFU];
    wr_t           wr;
    logic [NFU-1:0] req;
    logic [NFU-1:0] gnt;
    logic          wr_hit;
    logic          wr_do;
    logic          rd_hit;
    logic          rd_bad;
    logic          inc;
    logic          dec_rd;
    logic          dec_rp;
    rd_t           rd_q;
    rd_t           rd_nxt;

    // unpack FU ports and qualify requests against slot state
    always_comb begin
        for (int i = 0; i < NFU; i++) begin
            fu_a[i].tid = fu_tid[i*TW +: TW];
            fu_a[i].res = fu_res[i*DW +: DW];
            fu_a[i].nzv = fu_nzv[i*3 +: 3];
            fu_a[i].y   = fu_y[i*32 +: 32];
            req[i] = rstn & fu_valid[i] &
                     (!valid[fu_a[i].tid] |
                      (rd_en & (rd_tid == fu_a[i].tid)));
        end
    end

    xalu_rr_arb #(
        .N(NFU)
    ) u_arb (
        .clk  (gclk),
        .rstn (rstn),
        .req  (req),
        .gnt  (gnt)
    );

    assign fu_ready = gnt;

    // select the granted FU's write record
    always_comb begin
        wr     = '0;
        wr_hit = |gnt;
        for (int i = 0; i < NFU; i++) begin
            if (gnt[i]) wr = fu_a[i];
        end
        wr_do = wr_hit & !(replay_en & (replay_tid == wr.tid));
    end

`ifdef XALU_OBUF_PARITY_EN
    logic par_mem [NTHREAD];

    // parity bit written alongside the slot data
    always_ff @(posedge gclk) begin
        if (wr_do) par_mem[wr.tid] <= ^{wr.res, wr.nzv};
    end

    assign rd_bad = rd_hit &
                    (par_mem[rd_tid] ^ (^{res_mem[rd_tid], nzv_mem[rd_tid]}));
`else
    assign rd_bad = 1'b0;
`endif

    assign rd_hit = rd_en & valid[rd_tid];

    // next valid vector: replay over write over consume
    always_comb begin
        valid_nxt = valid;
        if (rd_en)     valid_nxt[rd_tid]     = 1'b0;
        if (wr_do)     valid_nxt[wr.tid]     = 1'b1;
        if (replay_en) valid_nxt[replay_tid] = 1'b0;
        inc    = wr_do & !valid[wr.tid];
        dec_rd = rd_hit &
                 !(wr_do & (wr.tid == rd_tid)) &
                 !(replay_en & (replay_tid == rd_tid));
        dec_rp = replay_en & valid[replay_tid];
    end

    // read data captured from pre-write slot contents
    always_comb begin
        rd_nxt = '0;
        if (rd_hit) begin
            rd_nxt.valid = !rd_bad;
            rd_nxt.res   = res_mem[rd_tid];
            rd_nxt.nzv   = nzv_mem[rd_tid];
            rd_nxt.y     = y_mem[rd_tid];
            rd_nxt.perr  = rd_bad;
        end
    end

    // slot data storage, intentionally not reset
    always_ff @(posedge gclk) begin
        if (wr_do) begin
            res_mem[wr.tid] <= wr.res;
            nzv_mem[wr.tid] <= wr.nzv;
            y_mem[wr.tid]   <= wr.y;
        end
    end

    // valid bits, occupancy and registered read port
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            valid   <= '0;
            occ_cnt <= '0;
            rd_q    <= '0;
        end else begin
            valid   <= valid_nxt;
            occ_cnt <= occ_cnt + (TW+1)'(inc)
                     - (TW+1)'(dec_rd) - (TW+1)'(dec_rp);
            rd_q    <= rd_nxt;
        end
    end

    assign rd_valid = rd_q.valid;
    assign rd_res   = rd_q.res;
    assign rd_nzv   = rd_q.nzv;
    assign rd_y     = rd_q.y;
    assign rd_perr  = rd_q.perr;

endmodule

// File: tb/tb_xalu_obuf_mt.sv
// Directed bench for xalu_obuf_mt with NTHREAD=64, NFU=2, DW=32.
// Parity scenario runs only when XALU_OBUF_PARITY_EN is defined.
module tb_xalu_obuf_mt;

    localparam int NT  = 64;
    localparam int NFU = 2;
    localparam int DW  = 32;
    localparam int TW  = 6;

    logic              gclk;
    logic              rstn;
    logic [NFU-1:0]    fu_valid;
    logic [NFU*TW-1:0] fu_tid;
    logic [NFU*DW-1:0] fu_res;
    logic [NFU*3-1:0]  fu_nzv;
    logic [NFU*32-1:0] fu_y;
    logic [NFU-1:0]    fu_ready;
    logic              rd_en;
    logic [TW-1:0]     rd_tid;
    logic              rd_valid;
    logic [DW-1:0]     rd_res;
    logic [2:0]        rd_nzv;
    logic [31:0]       rd_y;
    logic              rd_perr;
    logic              replay_en;
    logic [TW-1:0]     replay_tid;
    logic [TW:0]       occ_cnt;

    int n_chk;
    int n_err;

    xalu_obuf_mt #(
        .NTHREAD(NT),
        .NFU    (NFU),
        .DW     (DW)
    ) dut (
        .gclk      (gclk),
        .rstn      (rstn),
        .fu_valid  (fu_valid),
        .fu_tid    (fu_tid),
        .fu_res    (fu_res),
        .fu_nzv    (fu_nzv),
        .fu_y      (fu_y),
        .fu_ready  (fu_ready),
        .rd_en     (rd_en),
        .rd_tid    (rd_tid),
        .rd_valid  (rd_valid),
        .rd_res    (rd_res),
        .rd_nzv    (rd_nzv),
        .rd_y      (rd_y),
        .rd_perr   (rd_perr),
        .replay_en (replay_en),
        .replay_tid(replay_tid),
        .occ_cnt   (occ_cnt)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        fu_valid   = '0;
        fu_tid     = '0;
        fu_res     = '0;
        fu_nzv     = '0;
        fu_y       = '0;
        rd_en      = 1'b0;
        rd_tid     = '0;
        replay_en  = 1'b0;
        replay_tid = '0;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t,
                          input logic [31:0] r, input logic [2:0] n);
        fu_valid[i]        = 1'b1;
        fu_tid[i*TW +: TW] = t;
        fu_res[i*DW +: DW] = r;
        fu_nzv[i*3 +: 3]   = n;
        fu_y[i*32 +: 32]   = ~r;
    endtask

    // start of a cycle: inputs change at the falling edge
    task automatic cyc();
        @(negedge gclk);
        idle();
    endtask

    // registered outputs sampled just after the rising edge
    task automatic post();
        @(posedge gclk);
        #1;
    endtask

    task automatic rd(input logic [TW-1:0] t);
        rd_en  = 1'b1;
        rd_tid = t;
    endtask

    logic [1:0]    exp3 [4];
    logic [TW-1:0] t0;
    logic [TW-1:0] t1;

    initial begin
        n_chk = 0;
        n_err = 0;
        exp3  = '{2'b10, 2'b01, 2'b10, 2'b01};
        idle();
        rstn = 1'b0;

        // reset: FU requests ignored, counters clear
        @(negedge gclk);
        set_fu(0, 6'd1, 32'h1, 3'b0);
        set_fu(1, 6'd2, 32'h2, 3'b0);
        #1;
        chk("rst_ready", fu_ready, 2'b00);
        chk("rst_occ", occ_cnt, 0);
        chk("rst_rdv", rd_valid, 0);
        @(negedge gclk);
        idle();
        rstn = 1'b1;

        // read of empty slot
        cyc(); rd(6'd5);
        post();
        chk("t1_rdv", rd_valid, 0);
        chk("t1_res", rd_res, 0);
        chk("t1_occ", occ_cnt, 0);

        // single write then consume
        cyc(); set_fu(0, 6'd3, 32'h1234_5678, 3'b000);
        #1 chk("t2_ready", fu_ready, 2'b01);
        post();
        chk("t2_occ1", occ_cnt, 1);
        cyc(); rd(6'd3);
        post();
        chk("t2_rdv", rd_valid, 1);
        chk("t2_res", rd_res, 32'h1234_5678);
        chk("t2_nzv", rd_nzv, 3'b000);
        chk("t2_y", rd_y, 32'hEDCB_A987);
        chk("t2_perr", rd_perr, 0);
        chk("t2_occ0", occ_cnt, 0);

        // both FUs busy: grants alternate starting at FU1
        t0 = 6'd10;
        t1 = 6'd20;
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_fu(0, t0, 32'hA000_0000 | 32'(t0), 3'b001);
            set_fu(1, t1, 32'hB000_0000 | 32'(t1), 3'b010);
            #1 chk($sformatf("t3_gnt%0d", k), fu_ready, exp3[k]);
            if (exp3[k][0]) t0 = t0 + 6'd1;
            if (exp3[k][1]) t1 = t1 + 6'd1;
            post();
        end
        chk("t3_occ", occ_cnt, 4);
        cyc(); rd(6'd21);
        post();
        chk("t3_rdv", rd_valid, 1);
        chk("t3_res", rd_res, 32'hB000_0015);
        chk("t3_nzv", rd_nzv, 3'b010);
        chk("t3_occ2", occ_cnt, 3);

        // blocked write released by same-cycle consume
        cyc(); set_fu(0, 6'd7, 32'h7777_0000, 3'b100);
        #1 chk("t4_w0", fu_ready, 2'b01);
        post();
        chk("t4_occ", occ_cnt, 4);
        for (int k = 0; k < 2; k++) begin
            cyc(); set_fu(1, 6'd7, 32'h7777_1111, 3'b011);
            #1 chk($sformatf("t4_stall%0d", k), fu_ready, 2'b00);
            post();
        end
        cyc(); set_fu(1, 6'd7, 32'h7777_1111, 3'b011); rd(6'd7);
        #1 chk("t4_rel", fu_ready, 2'b10);
        post();
        chk("t4_rdv", rd_valid, 1);
        chk("t4_old", rd_res, 32'h7777_0000);
        chk("t4_occ2", occ_cnt, 4);
        cyc(); rd(6'd7);
        post();
        chk("t4_new", rd_res, 32'h7777_1111);
        chk("t4_nzv", rd_nzv, 3'b011);
        chk("t4_occ3", occ_cnt, 3);

        // replay discards a same-cycle write
        cyc(); set_fu(0, 6'd9, 32'h9999_9999, 3'b000);
        replay_en = 1'b1; replay_tid = 6'd9;
        #1 chk("t5_ready", fu_ready, 2'b01);
        post();
        chk("t5_occ", occ_cnt, 3);
        cyc(); rd(6'd9);
        post();
        chk("t5_rdv", rd_valid, 0);
        chk("t5_res", rd_res, 0);

        // replay beats read: data returned, slot ends invalid
        cyc(); rd(6'd10); replay_en = 1'b1; replay_tid = 6'd10;
        post();
        chk("t5b_rdv", rd_valid, 1);
        chk("t5b_res", rd_res, 32'hA000_000A);
        chk("t5b_occ", occ_cnt, 2);
        cyc(); rd(6'd10);
        post();
        chk("t5b_rdv2", rd_valid, 0);
        chk("t5b_occ2", occ_cnt, 2);

        // two FUs on one tid: loser is blocked afterwards
        cyc();
        set_fu(0, 6'd30, 32'hC000_001E, 3'b000);
        set_fu(1, 6'd30, 32'hD000_001E, 3'b000);
        #1 chk("t7_gnt", fu_ready, 2'b10);
        post();
        chk("t7_occ", occ_cnt, 3);
        cyc(); set_fu(0, 6'd30, 32'hC000_001E, 3'b000);
        #1 chk("t7_blk", fu_ready, 2'b00);
        post();
        cyc(); rd(6'd30);
        post();
        chk("t7_res", rd_res, 32'hD000_001E);
        chk("t7_occ2", occ_cnt, 2);

`ifdef XALU_OBUF_PARITY_EN
        // corrupted stored result flagged on read
        cyc(); set_fu(0, 6'd2, 32'h0000_0F0F, 3'b000);
        #1 chk("t6_ready", fu_ready, 2'b01);
        post();
        chk("t6_occ", occ_cnt, 3);
        @(negedge gclk);
        dut.res_mem[2][0] = ~dut.res_mem[2][0];
        cyc(); rd(6'd2);
        post();
        chk("t6_perr", rd_perr, 1);
        chk("t6_rdv", rd_valid, 0);
        chk("t6_occ2", occ_cnt, 2);
`endif

        cyc();
        post();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
